// File: rtl/freq_step_ctrl.sv
// freq_step_ctrl: debounced up/down buttons and ping-pong sweep stepping an 11-bit divider count
module freq_step_ctrl #(
  parameter int DIV_MIN   = 1,
  parameter int DIV_MAX   = 2047,
  parameter int DIV_INIT  = 999,
  parameter int STEP      = 50,
  parameter int DEB_TICKS = 20,
  parameter int DWELL     = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1khz,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        sweep_en,
  output logic [10:0] div,
  output logic        div_load,
  output logic        busy,
  output logic        at_min,
  output logic        at_max
);
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int WW = $clog2(DWELL + 1);
  typedef enum logic [2:0] {IDLE, DEBOUNCE, APPLY, HOLD, SWEEP} state_t;
  state_t state_q, state_d;
  logic [2:0] sync1_q, sync_q;
  logic [DW-1:0] deb_q, deb_d;
  logic [WW-1:0] dwell_q, dwell_d;
  logic btn_dir_q, btn_dir_d, swp_dir_q, swp_dir_d;
  logic [10:0] div_q, div_d;
  logic load_q, busy_q, min_q, max_q;
  logic up_s, dn_s, sw_s, step_up, latched, other, dwell_end;
  logic [11:0] sum, dif;
  logic [10:0] stepped;
  always_comb begin
    up_s = sync_q[0];
    dn_s = sync_q[1];
    sw_s = sync_q[2];
    latched = btn_dir_q ? up_s : dn_s;
    other = btn_dir_q ? dn_s : up_s;
    step_up = state_q == SWEEP ? swp_dir_q : btn_dir_q;
    sum = {1'b0, div_q} + 12'(STEP);
    dif = {1'b0, div_q} - 12'(STEP);
    stepped = step_up ? (sum > 12'(DIV_MAX) ? 11'(DIV_MAX) : sum[10:0])
                      : ((dif[11] || dif < 12'(DIV_MIN)) ? 11'(DIV_MIN) : dif[10:0]);
    dwell_end = dwell_q == WW'(DWELL - 1);
    state_d = state_q;
    deb_d = deb_q;
    dwell_d = dwell_q;
    btn_dir_d = btn_dir_q;
    swp_dir_d = swp_dir_q;
    div_d = div_q;
    case (state_q)
      IDLE:
        if (sw_s) begin
          state_d = SWEEP;
          swp_dir_d = 1'b1;
          dwell_d = '0;
        end else if (up_s ^ dn_s) begin
          state_d = DEBOUNCE;
          btn_dir_d = up_s;
          deb_d = '0;
        end
      DEBOUNCE:
        if (!latched || other) state_d = IDLE;
        else if (tick_1khz) begin
          deb_d = deb_q + 1'b1;
          state_d = deb_q == DW'(DEB_TICKS - 1) ? APPLY : DEBOUNCE;
        end
      APPLY: begin
        div_d = stepped;
        state_d = HOLD;
      end
      HOLD: state_d = (!up_s && !dn_s) ? IDLE : HOLD;
      SWEEP:
        if (!sw_s) begin
          state_d = IDLE;
          dwell_d = '0;
        end else if (tick_1khz) begin
          dwell_d = dwell_end ? '0 : dwell_q + 1'b1;
          div_d = dwell_end ? stepped : div_q;
          swp_dir_d = (dwell_end && stepped == (swp_dir_q ? 11'(DIV_MAX) : 11'(DIV_MIN))) ? !swp_dir_q : swp_dir_q;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync_q <= '0;
      deb_q <= '0;
      dwell_q <= '0;
      btn_dir_q <= 1'b0;
      swp_dir_q <= 1'b1;
      div_q <= 11'(DIV_INIT);
      load_q <= 1'b0;
      busy_q <= 1'b0;
      min_q <= DIV_INIT == DIV_MIN;
      max_q <= DIV_INIT == DIV_MAX;
    end else begin
      state_q <= state_d;
      sync1_q <= {sweep_en, btn_dn, btn_up};
      sync_q <= sync1_q;
      deb_q <= deb_d;
      dwell_q <= dwell_d;
      btn_dir_q <= btn_dir_d;
      swp_dir_q <= swp_dir_d;
      div_q <= div_d;
      load_q <= div_d != div_q;
      busy_q <= state_d != IDLE;
      min_q <= div_d == 11'(DIV_MIN);
      max_q <= div_d == 11'(DIV_MAX);
    end
  assign div = div_q;
  assign div_load = load_q;
  assign busy = busy_q;
  assign at_min = min_q;
  assign at_max = max_q;
endmodule

// File: tb/tb_freq_step_ctrl.sv
// tb_freq_step_ctrl: randomized scoreboard bench for freq_step_ctrl against a behavioural model
module tb_freq_step_ctrl;
  localparam int DMIN = 1, DMAX = 2047, DINIT = 999, STP = 1000, DEB = 5, DWL = 2;
  logic clk = 0, rst = 1, tick_1khz = 0, btn_up = 0, btn_dn = 0, sweep_en = 0;
  logic [10:0] div;
  logic div_load, busy, at_min, at_max;
  typedef struct packed {logic [10:0] div; logic load; logic busy; logic amin; logic amax;} rec_t;
  typedef enum {M_IDLE, M_PRESS, M_STEP, M_WAIT, M_SWEEP} mode_t;
  rec_t exp_q[$];
  rec_t r, m_e, m_a;
  int loads[$];
  int checks = 0, errors = 0, tcnt = 0;
  bit rnd_tick = 0;
  mode_t m_mode = M_IDLE;
  int m_div = DINIT, m_ticks = 0, m_dwell = 0;
  bit m_press_up = 0, m_sweep_up = 1;
  logic [2:0] h1 = 0, h2 = 0;
  int sw_exp[6] = '{1999, 2047, 1047, 47, 1, 1001};
  freq_step_ctrl #(.DIV_MIN(DMIN), .DIV_MAX(DMAX), .DIV_INIT(DINIT), .STEP(STP), .DEB_TICKS(DEB), .DWELL(DWL)) dut (
    .clk(clk), .rst(rst), .tick_1khz(tick_1khz), .btn_up(btn_up), .btn_dn(btn_dn), .sweep_en(sweep_en),
    .div(div), .div_load(div_load), .busy(busy), .at_min(at_min), .at_max(at_max)
  );
  always #5 clk = ~clk;
  function automatic int bump(input int v, input bit up);
    return up ? (v + STP > DMAX ? DMAX : v + STP) : (v - STP < DMIN ? DMIN : v - STP);
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic model_edge();
    int old;
    bit u, d, s;
    old = m_div;
    u = h2[0];
    d = h2[1];
    s = h2[2];
    if (rst) begin
      m_mode = M_IDLE;
      m_div = DINIT;
      h1 = 0;
      h2 = 0;
      m_ticks = 0;
      m_dwell = 0;
    end else begin
      h2 = h1;
      h1 = {sweep_en, btn_dn, btn_up};
      case (m_mode)
        M_IDLE:
          if (s) begin
            m_mode = M_SWEEP;
            m_sweep_up = 1;
            m_dwell = 0;
          end else if (u != d) begin
            m_mode = M_PRESS;
            m_press_up = u;
            m_ticks = 0;
          end
        M_PRESS:
          if (m_press_up ? (!u || d) : (!d || u)) m_mode = M_IDLE;
          else if (tick_1khz) begin
            m_ticks++;
            if (m_ticks == DEB) m_mode = M_STEP;
          end
        M_STEP: begin
          m_div = bump(m_div, m_press_up);
          m_mode = M_WAIT;
        end
        M_WAIT: if (!u && !d) m_mode = M_IDLE;
        M_SWEEP:
          if (!s) m_mode = M_IDLE;
          else if (tick_1khz) begin
            m_dwell++;
            if (m_dwell == DWL) begin
              m_dwell = 0;
              m_div = bump(m_div, m_sweep_up);
              if (m_div == (m_sweep_up ? DMAX : DMIN)) m_sweep_up = !m_sweep_up;
            end
          end
      endcase
    end
    r.div = 11'(m_div);
    r.load = !rst && m_div != old;
    r.busy = m_mode != M_IDLE;
    r.amin = m_div == DMIN;
    r.amax = m_div == DMAX;
    exp_q.push_back(r);
  endtask
  always @(negedge clk) begin
    if (div_load) loads.push_back(int'(div));
    if (exp_q.size() != 0) begin
      m_e = exp_q.pop_front();
      m_a = {div, div_load, busy, at_min, at_max};
      checks++;
      if (m_a !== m_e) begin
        errors++;
        $display("FAIL cycle_out @%0t: got div=%0d load=%0b busy=%0b min=%0b max=%0b expected div=%0d load=%0b busy=%0b min=%0b max=%0b",
                 $time, m_a.div, m_a.load, m_a.busy, m_a.amin, m_a.amax, m_e.div, m_e.load, m_e.busy, m_e.amin, m_e.amax);
      end
    end
  end
  task automatic cyc(input bit u, input bit d, input bit s, input bit rr = 0);
    @(negedge clk);
    #1;
    btn_up = u;
    btn_dn = d;
    sweep_en = s;
    rst = rr;
    tick_1khz = rnd_tick ? ($urandom_range(0, 2) == 0) : (tcnt % 3 == 0);
    tcnt++;
    @(posedge clk);
    model_edge();
  endtask
  task automatic hold(input int n, input bit u, input bit d, input bit s);
    repeat (n) cyc(u, d, s);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1;
    btn_up = 0;
    btn_dn = 0;
    sweep_en = 0;
    tick_1khz = 0;
    #1;
    chk("rst_async_div", int'(div), DINIT);
    chk("rst_async_flags", int'({div_load, busy, at_min, at_max}), 0);
    @(posedge clk);
    model_edge();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
  endtask
  task automatic pt(input string nm, input int act, input int exp);
    #1 chk(nm, act, exp);
  endtask
  initial begin
    bit u, d, s;
    do_reset();
    pt("reset_div", int'(div), DINIT);
    hold(40, 1, 0, 0);
    hold(6, 0, 0, 0);
    pt("up_press", int'(div), 1999);
    pt("up_idle", int'(busy), 0);
    hold(6, 0, 1, 0);
    hold(6, 0, 0, 0);
    pt("dn_glitch", int'(div), 1999);
    hold(40, 1, 0, 0);
    hold(6, 0, 0, 0);
    pt("sat_max", int'({div, at_max}), (2047 << 1) | 1);
    hold(40, 1, 0, 0);
    hold(6, 0, 0, 0);
    pt("sat_again", int'(div), 2047);
    hold(60, 1, 1, 0);
    pt("both_busy", int'(busy), 0);
    hold(40, 0, 1, 0);
    hold(6, 0, 0, 0);
    pt("dn_press", int'(div), 1047);
    do_reset();
    loads.delete();
    hold(120, 0, 0, 1);
    hold(10, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (loads.size() > i) chk("sweep_seq", loads[i], sw_exp[i]);
      else chk("sweep_seq_len", loads.size(), i + 1);
    end
    hold(12, 1, 0, 0);
    do_reset();
    hold(30, 0, 0, 0);
    pt("rst_mid_deb", int'(div), DINIT);
    rnd_tick = 1;
    u = 0;
    d = 0;
    s = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) u = !u;
      if ($urandom_range(0, 15) == 0) d = !d;
      if ($urandom_range(0, 59) == 0) s = !s;
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc(u, d, s);
    end
    @(negedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_step_ctrl.md
FREQ_STEP_CTRL -- requirements
Module: freq_step_ctrl

Interface
REQ-001 Parameter DIV_MIN, 1, lowest legal divider count.
REQ-002 Parameter DIV_MAX, 2047, highest legal divider count.
REQ-003 Parameter DIV_INIT, 999, divider count after reset.
REQ-004 Parameter STEP, 50, increment/decrement per accepted press or sweep step.
REQ-005 Parameter DEB_TICKS, 20, stable 1 kHz ticks required to accept a press.
REQ-006 Parameter DWELL, 100, 1 kHz ticks between sweep steps.
REQ-007 clk  input  1  system clock.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 tick_1khz  input  1  single-cycle enable from the fixed 1 kHz divider output, clk-synchronous.
REQ-010 btn_up  input  1  raw pushbutton, increase divider count.
REQ-011 btn_dn  input  1  raw pushbutton, decrease divider count.
REQ-012 sweep_en  input  1  level; high selects automatic ping-pong sweep.
REQ-013 div  output  11  registered divider count for the variable clock divider.
REQ-014 div_load  output  1  one-cycle strobe, high in the cycle div first shows a new value.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 at_min  output  1  high while div == DIV_MIN.
REQ-017 at_max  output  1  high while div == DIV_MAX.

Function
REQ-018 btn_up, btn_dn, sweep_en SHALL each pass a 2-flop synchronizer; all logic SHALL use only the synchronized versions (2-cycle input latency).
REQ-019 FSM states SHALL be IDLE, DEBOUNCE, APPLY, HOLD, SWEEP.
REQ-020 IDLE: sweep_en_s -> SWEEP (priority); else exactly one button high -> DEBOUNCE, latching direction, deb_cnt=0; both or neither high -> stay IDLE.
REQ-021 DEBOUNCE: latched button low, or the other button high -> IDLE without change; each tick_1khz increments deb_cnt; tick while deb_cnt == DEB_TICKS-1 -> APPLY.
REQ-022 APPLY SHALL last exactly one cycle, update div on its exit edge, and go to HOLD.
REQ-023 HOLD: stay until both synchronized buttons low, then IDLE; no auto-repeat.
REQ-024 Step arithmetic SHALL use 12-bit intermediate: up = min(div+STEP, DIV_MAX), down = max(div-STEP, DIV_MIN), never wrapping.
REQ-025 div_load SHALL pulse for one cycle only when div actually changes; a saturated step with no change SHALL produce no strobe.
REQ-026 SWEEP: dwell counter counts tick_1khz; tick at count DWELL-1 clears the counter and steps div in the sweep direction per REQ-024 with div_load.
REQ-027 Sweep direction SHALL start up on each entry to SWEEP and reverse on the step that reaches DIV_MAX (to down) or DIV_MIN (to up).
REQ-028 In SWEEP buttons SHALL be ignored; sweep_en_s low -> IDLE next cycle, div retained, dwell counter cleared.
REQ-029 tick_1khz coincident with a state exit SHALL be discarded, not carried into the next state.
REQ-030 busy, at_min, at_max SHALL be registered, consistent with div/state in the same cycle.

Reset
REQ-031 rst SHALL asynchronously force state=IDLE, div=DIV_INIT, div_load=0, busy=0, all counters and synchronizers 0, sweep direction up.
REQ-032 at_min/at_max SHALL reflect DIV_INIT during reset (0/0 for defaults).
REQ-033 Reset mid-DEBOUNCE, APPLY or SWEEP SHALL discard pending action; no div_load on release of reset.

Verification
REQ-034 btn_up held 25 ticks from reset -> single div_load, div 999->1049; release -> busy low.
REQ-035 btn_dn glitch held 10 ticks then released -> no div_load, div stays 999, return to IDLE.
REQ-036 div at 2022, btn_up accepted -> div=2047, at_max=1; second press -> no div_load, div stays 2047.
REQ-037 btn_up and btn_dn both high 30 ticks -> no change, busy stays 0.
REQ-038 sweep_en high, DWELL=2, STEP=1000, DIV_INIT=999 -> div 1999, 2047 (at_max), 1047, 47, 1 (at_min), 1001 every 2 ticks; sweep_en low -> div held.
REQ-039 rst asserted at deb_cnt=15 during btn_up press -> div=999 immediately, no div_load after release of rst.
